// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants and FSM state encoding for the iterative
// signed multiply/divide unit.
//   WIDTH      - operand/result width (only 32 is supported)
//   ITERATIONS - datapath steps per operation (one bit per cycle)
//   state_t    - FSM states IDLE, MULT, DIV, DONE
//   magnitude  - absolute value of a two's-complement word, read as unsigned
package multdiv_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The most negative value maps to itself, which is still the correct
    // magnitude when the result is interpreted as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: 32-bit adder/subtractor shared by the multiply (Booth) and
// divide (restoring) datapaths.
//   a, b - operands
//   sub  - 0: sum = a + b, 1: sum = a - b (a + ~b + 1)
//   sum  - low 32 bits of the result
//   cout - carry out of bit 31; for subtraction, 1 means no borrow (a >= b unsigned)
module multdiv_addsub
    import multdiv_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff       = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/multdiv.sv
// multdiv: iterative signed 32x32 multiplier (radix-2 Booth, low product word)
// and signed divider (restoring on magnitudes, quotient truncated toward zero).
// Fixed latency: start pulse in cycle N gives data_resultRDY in cycle N+33.
//   clock, reset   - single clock, synchronous active-high reset
//   data_operandA  - multiplicand / dividend
//   data_operandB  - multiplier / divisor
//   ctrl_MULT      - start multiply (wins when both starts are high)
//   ctrl_DIV       - start divide
//   data_result    - product low word or quotient, held until the next start
//   data_exception - product overflow, divide by zero, or MIN/-1 overflow
//   data_resultRDY - one-cycle pulse marking a fresh result
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    state_t      state;
    logic [5:0]  count;
    // hi/lo hold the Booth product {hi, lo} for multiply, and the partial
    // remainder (hi) with the dividend shifting into the quotient (lo) for divide.
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] opb;       // multiplicand, or divisor magnitude
    logic        booth_q;   // Booth q(-1) bit
    logic        neg;       // quotient sign
    logic        div_zero;
    logic        div_ovf;

    logic [31:0] as_a;
    logic [31:0] as_sum;
    logic        as_sub;
    logic        as_cout;

    logic [32:0] booth_hi;
    logic [31:0] div_shift;
    logic [31:0] next_hi;
    logic [31:0] next_lo;
    logic [31:0] final_result;
    logic        final_exc;

    multdiv_addsub u_addsub (
        .a   (as_a),
        .b   (opb),
        .sub (as_sub),
        .sum (as_sum),
        .cout(as_cout)
    );

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        as_a         = hi;
        as_sub       = 1'b0;
        booth_hi     = {hi[31], hi};
        div_shift    = {hi[30:0], lo[31]};
        next_hi      = hi;
        next_lo      = lo;
        final_result = '0;
        final_exc    = 1'b0;

        if (state == ST_DIV) begin
            // Remainder stays below the divisor (<= 2^31), so the shifted
            // value fits in 32 unsigned bits; cout = 1 means it fits the divisor.
            as_a    = div_shift;
            as_sub  = 1'b1;
            next_hi = as_cout ? as_sum : div_shift;
            next_lo = {lo[30:0], as_cout};
            if (div_zero) begin
                final_result = '0;
                final_exc    = 1'b1;
            end else if (div_ovf) begin
                final_result = 32'h8000_0000;
                final_exc    = 1'b1;
            end else begin
                final_result = neg ? -next_lo : next_lo;
                final_exc    = 1'b0;
            end
        end else begin
            // Booth pair {lo[0], q(-1)}: 01 adds, 10 subtracts the multiplicand.
            // The add can overflow 32 bits, so the true sign of the 33-bit sum
            // is rebuilt from the operand signs and the carry before the
            // arithmetic shift.
            as_sub = lo[0] & ~booth_q;
            if (lo[0] ^ booth_q) begin
                booth_hi = {hi[31] ^ opb[31] ^ as_sub ^ as_cout, as_sum};
            end
            next_hi      = booth_hi[32:1];
            next_lo      = {booth_hi[0], lo[31:1]};
            final_result = next_lo;
            final_exc    = (next_hi != {32{next_lo[31]}});
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            count          <= '0;
            hi             <= '0;
            lo             <= '0;
            opb            <= '0;
            booth_q        <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            // Accepted in any state: aborts a running operation silently.
            count          <= '0;
            hi             <= '0;
            booth_q        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            if (ctrl_MULT) begin
                state    <= ST_MULT;
                lo       <= data_operandB;
                opb      <= data_operandA;
                neg      <= 1'b0;
                div_zero <= 1'b0;
                div_ovf  <= 1'b0;
            end else begin
                state    <= ST_DIV;
                lo       <= magnitude(data_operandA);
                opb      <= magnitude(data_operandB);
                neg      <= data_operandA[31] ^ data_operandB[31];
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == 32'h8000_0000) &&
                            (data_operandB == 32'hFFFF_FFFF);
            end
        end else begin
            case (state)
                ST_MULT, ST_DIV: begin
                    hi    <= next_hi;
                    lo    <= next_lo;
                    count <= count + 6'd1;
                    if (state == ST_MULT) begin
                        booth_q <= lo[0];
                    end
                    // Leaving on the last step keeps the counter at 32.
                    if (count == 6'(ITERATIONS - 1)) begin
                        state          <= ST_DONE;
                        data_result    <= final_result;
                        data_exception <= final_exc;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign data_resultRDY = (state == ST_DONE);

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed vectors with a scoreboard. Stimulus pushes the
// expected result, exception and RDY cycle; a monitor pops on every RDY.
module tb_multdiv;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    multdiv #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    int edges = 0;
    always @(posedge clock) edges++;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every RDY must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                check("rdy_with_nothing_pending", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_cycle"}, 64'(edges), 64'(e.cyc));
                check({e.name, "_result"}, 64'(data_result), 64'(e.res));
                check({e.name, "_exc"}, 64'(data_exception), 64'(e.exc));
            end
        end
    end

    // Drives one start pulse from the current negedge; returns at the next
    // negedge after scrambling the operands to show they were latched.
    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic expect_it,
                         input logic [31:0] er, input logic ee, input string name);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (expect_it) begin
            e.res = er;
            e.exc = ee;
            e.cyc = edges + 33;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            check("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic run(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er,
                       input logic ee, input string name);
        issue(m, d, a, b, 1'b1, er, ee, name);
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exc", 64'(data_exception), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);

        // Multiply vectors.
        run(1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, "mul_7_m6");
        repeat (3) @(negedge clock);
        check("hold_result", 64'(data_result), 64'hFFFF_FFD6);
        check("hold_exc", 64'(data_exception), 64'd0);
        issue(1, 0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 1'b1, "mul_2p32");
        check("clear_on_start_result", 64'(data_result), 64'd0);
        wait_done();
        run(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, "mul_m1_m1");
        run(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_m1");
        run(1, 1, 32'd6, 32'd3, 32'd18, 1'b0, "both_mult_wins");

        // Divide vectors.
        run(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        run(0, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100_m7");
        run(0, 1, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, "div_min_2");
        run(0, 1, 32'd3, 32'd7, 32'd0, 1'b0, "div_3_7");
        run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min_m1");
        run(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, "div_5_0");

        // Reset clears a held exception.
        check("held_exc_before_reset", 64'(data_exception), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("reset_clears_exc", 64'(data_exception), 64'd0);

        // Restart while busy: 3*4 is aborted by 100/7 ten cycles later.
        issue(1, 0, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, "");
        repeat (9) @(negedge clock);
        issue(0, 1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, "abort_div_100_7");
        wait_done();

        // Start accepted in the DONE cycle; both results must appear.
        issue(1, 0, 32'd5, 32'd5, 1'b1, 32'd25, 1'b0, "done_first");
        for (int i = 0; i < 40 && data_resultRDY !== 1'b1; i++) @(negedge clock);
        issue(0, 1, 32'd50, 32'd5, 1'b1, 32'd10, 1'b0, "done_second");
        wait_done();

        // Reset at cycle 15 of a multiply: no RDY ever for it.
        issue(1, 0, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, "");
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_reset_result", 64'(data_result), 64'd0);
        check("abort_reset_exc", 64'(data_exception), 64'd0);
        check("abort_reset_rdy", 64'(data_resultRDY), 64'd0);
        repeat (40) @(negedge clock);
        run(1, 0, 32'd2, 32'd2, 32'd4, 1'b0, "mul_2_2_after_reset");

        repeat (5) @(negedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
